truth_table_sweeper: RTL and testbench

Sequential stimulus-and-capture stage that sits directly upstream of a 4-input, 1-output combinational gate netlist. It drives the gate inputs `_0`..`_3` through all 16 input rows, samples the gate output `_4` after a programmable settle time, and assembles the captured 16-bit truth table. It compares that table against an expected hex code and reports pass/fail plus a mismatch count. Its purpose is exhaustive equivalence checking of synthesized gate designs.

---
 rtl/truth_table_sweeper.sv | 119 +++++++++++
 tb/tb_truth_table_sweeper.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// Exhaustive 4-input truth-table sweeper and checker for a gate netlist.
// Define SWEEP_GRAY_EN to step rows in Gray order instead of binary order.
module truth_table_sweeper #(
    parameter logic [15:0] EXPECTED = 16'h4724,
    parameter int unsigned SETTLE   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        resp,
    output logic [3:0]  stim,
    output logic        busy,
    output logic        done,
    output logic [15:0] table_out,
    output logic        pass,
    output logic [4:0]  err_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [3:0]  r_step;
    logic [7:0]  r_cnt;
    logic [3:0]  r_stim;
    logic        r_busy;
    logic        r_done;
    logic [15:0] r_table;
    logic        r_pass;
    logic [4:0]  r_err;

    logic [3:0]  w_row;
    logic [3:0]  w_idx;
    logic        w_last;

    function automatic logic [3:0] row_of(input logic [3:0] k);
`ifdef SWEEP_GRAY_EN
        return k ^ (k >> 1);
`else
        return k;
`endif
    endfunction

    assign w_row  = row_of(r_step);
    // Row 0 lands in the table MSB so the hex code reads row 0 first.
    assign w_idx  = 4'd15 - w_row;
    assign w_last = (r_cnt == 8'(SETTLE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_step  <= 4'd0;
            r_cnt   <= 8'd0;
            r_stim  <= 4'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_table <= 16'd0;
            r_pass  <= 1'b0;
            r_err   <= 5'd0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        r_state <= S_SETTLE;
                        r_step  <= 4'd0;
                        r_cnt   <= 8'd0;
                        r_stim  <= row_of(4'd0);
                        r_busy  <= 1'b1;
                        r_table <= 16'd0;
                        r_err   <= 5'd0;
                        r_pass  <= 1'b0;
                    end
                end
                S_SETTLE: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_stim  <= 4'd0;
                        r_busy  <= 1'b0;
                        r_pass  <= 1'b0;
                    end else if (w_last) begin
                        r_table[w_idx] <= resp;
                        if (resp != EXPECTED[w_idx])
                            r_err <= r_err + 5'd1;
                        if (r_step == 4'd15) begin
                            r_state <= S_DONE;
                        end else begin
                            r_step <= r_step + 4'd1;
                            r_stim <= row_of(r_step + 4'd1);
                            r_cnt  <= 8'd0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_stim  <= 4'd0;
                    r_pass  <= (r_err == 5'd0);
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign stim      = r_stim;
    assign busy      = r_busy;
    assign done      = r_done;
    assign table_out = r_table;
    assign pass      = r_pass;
    assign err_count = r_err;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: ideal gate, stuck-at,
// abort, ignored start, async reset, and (with SWEEP_GRAY_EN) Gray order.
module tb_truth_table_sweeper;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        resp;
    logic [3:0]  stim;
    logic        busy;
    logic        done;
    logic [15:0] table_out;
    logic        pass;
    logic [4:0]  err_count;

    logic [15:0] gate_tt;
    int          mode;
    int          n_checks;
    int          n_fail;

    truth_table_sweeper #(
        .EXPECTED (16'h4724),
        .SETTLE   (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .resp      (resp),
        .stim      (stim),
        .busy      (busy),
        .done      (done),
        .table_out (table_out),
        .pass      (pass),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural gate: mode 0 ideal, 1 stuck-at-0, 2 stuck-at-1.
    assign resp = (mode == 0) ? gate_tt[4'd15 - stim] :
                  (mode == 1) ? 1'b0 : 1'b1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] tb_row(input int k);
        logic [3:0] kk;
        kk = 4'(k);
`ifdef SWEEP_GRAY_EN
        return kk ^ (kk >> 1);
`else
        return kk;
`endif
    endfunction

    // Runs one sweep from a negedge; re-pulses start at cycle restart_at.
    task automatic sweep(input string tag, input int restart_at,
                         output int dcyc);
        int cyc;
        int bad;
        int hops;
        logic [3:0] prev;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc  = 0;
        dcyc = -1;
        bad  = 0;
        hops = 0;
        prev = 4'd0;
        while (cyc < 60 && dcyc < 0) begin
            @(negedge clk);
            start = (cyc == restart_at);
            if (cyc < 32) begin
                if (stim !== tb_row(cyc / 2) || busy !== 1'b1)
                    bad++;
                if (cyc > 0 && cyc % 2 == 0 &&
                    $countones(stim ^ prev) != 1)
                    hops++;
                prev = stim;
            end
            if (done === 1'b1) begin
                dcyc = cyc;
                check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
                check({tag, "_stim_at_done"}, 32'(stim), 32'd0);
            end else begin
                @(posedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        check({tag, "_stim_seq_bad"}, 32'(bad), 32'd0);
`ifdef SWEEP_GRAY_EN
        check({tag, "_gray_hops_bad"}, 32'(hops), 32'd0);
`endif
        check({tag, "_done_cycle"}, 32'(dcyc), 32'd33);
        @(negedge clk);
        check({tag, "_done_pulse_end"}, 32'(done), 32'd0);
    endtask

    task automatic wait_stim(input logic [3:0] v);
        int n;
        n = 0;
        while (stim !== v && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("wait_stim_timeout", 32'(n < 60), 32'd1);
    endtask

    initial begin
        int dc;
        int dones;
        n_checks = 0;
        n_fail   = 0;
        gate_tt  = 16'h4724;
        mode     = 0;
        start    = 1'($urandom);
        abort    = 1'($urandom);
        rst_n    = 1'b0;
        #1;
        check("rst_outputs",
              {stim, busy, done, table_out, pass, err_count}, 32'd0);
        repeat (2) @(negedge clk);
        check("rst_hold",
              {stim, busy, done, table_out, pass, err_count}, 32'd0);
        start = 1'b0;
        abort = 1'b0;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_after_rst",
              {stim, busy, done, table_out, pass, err_count}, 32'd0);

        sweep("ideal", -1, dc);
        check("ideal_table", 32'(table_out), 32'h4724);
        check("ideal_err", 32'(err_count), 32'd0);
        check("ideal_pass", 32'(pass), 32'd1);
        repeat (3) @(negedge clk);
        check("hold_table", 32'(table_out), 32'h4724);
        check("hold_pass", 32'(pass), 32'd1);

        mode = 1;
        sweep("sa0", -1, dc);
        check("sa0_table", 32'(table_out), 32'h0000);
        check("sa0_err", 32'(err_count), 32'd6);
        check("sa0_pass", 32'(pass), 32'd0);

        mode = 2;
        sweep("sa1", -1, dc);
        check("sa1_table", 32'(table_out), 32'hFFFF);
        check("sa1_err", 32'(err_count), 32'd10);
        check("sa1_pass", 32'(pass), 32'd0);

        mode = 0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_stim(4'd7);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_stim", 32'(stim), 32'd0);
        check("abort_pass", 32'(pass), 32'd0);
        check("abort_err", 32'(err_count), 32'd0);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        sweep("after_abort", -1, dc);
        check("after_abort_table", 32'(table_out), 32'h4724);
        check("after_abort_pass", 32'(pass), 32'd1);

        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        check("abort_wins_busy", 32'(busy), 32'd0);
        check("abort_wins_pass", 32'(pass), 32'd1);

        sweep("restart", 10, dc);
        check("restart_table", 32'(table_out), 32'h4724);

        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_stim(4'd5);
        rst_n = 1'b0;
        #1;
        check("midrst_outputs",
              {stim, busy, done, table_out, pass, err_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) dones++;
        end
        check("midrst_quiet", 32'(dones), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
